// File: rtl/pipearch_common.sv
// Shared CCI-P types and helpers for the pipearch c0 request path.
// Carries the header layouts, the mdata tag field position used to
// route read responses back to their instance, and the line-cost helper.
package pipearch_common;

  // Bits of mdata that carry the source instance index.
  localparam int MDATA_TAG_HI = 15;
  localparam int MDATA_TAG_LO = 14;

  // Default per-instance cache-line credit limit.
  localparam int CCIP_MAX_OUTSTANDING = 64;

  // Width of a line cost (1..4).
  localparam int CCIP_LINES_W = 3;

  typedef logic [$clog2(CCIP_MAX_OUTSTANDING + 1)-1:0] t_outstanding_cnt;

  typedef logic [41:0] t_ccip_clAddr;
  typedef logic [15:0] t_ccip_mdata;

  // Multi-line request length. 2'b10 is not a legal encoding.
  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_cci_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_cci_c0_rsp;

  typedef struct packed {
    logic [1:0]   vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_cci_c0_req  req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_cci_c0_ReqMemHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    t_cci_c0_rsp resp_type;
    t_ccip_mdata mdata;
  } t_cci_c0_RspMemHdr;

  // Cache lines consumed by a request: cl_len + 1. The illegal 2'b10
  // encoding falls out naturally as a cost of 3.
  function automatic logic [CCIP_LINES_W-1:0] ccip_lines(input t_ccip_clLen cl_len);
    return {1'b0, cl_len} + 3'd1;
  endfunction

endpackage

// File: rtl/ccip_c0_req_arbiter_credit.sv
// Per-instance outstanding cache-line counter. Grants add the request's
// line cost, tagged read responses return one line each, and both can
// land in the same cycle as a single net update.
module ccip_credit_counter
  import pipearch_common::*;
#(
  parameter int MAX_OUTSTANDING = CCIP_MAX_OUTSTANDING,
  parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    inc_en,
  input  logic [CCIP_LINES_W-1:0] inc_lines,
  input  logic                    dec_en,
  input  logic [CCIP_LINES_W-1:0] chk_lines,
  output logic [CNT_BITS-1:0]     count,
  output logic                    has_room,
  output logic                    underflow
);

  // One extra bit so count + lines cannot wrap before the limit compare.
  localparam int W = CNT_BITS + 1;

  logic [W-1:0]        count_ext;
  logic [W-1:0]        room_sum;
  logic [W-1:0]        base;
  logic [W-1:0]        next_ext;
  logic                underflow_now;
  logic [CNT_BITS-1:0] count_nxt;

  // Room check and next count; room uses only the registered count so a
  // response this cycle cannot combinationally open up a grant.
  always_comb begin
    count_ext     = {1'b0, count};
    room_sum      = count_ext + W'(chk_lines);
    has_room      = (room_sum <= W'(MAX_OUTSTANDING));
    base          = count_ext + (inc_en ? W'(inc_lines) : '0);
    underflow_now = dec_en && (base == '0);
    next_ext      = (dec_en && (base != '0)) ? (base - W'(1)) : base;
    count_nxt     = next_ext[CNT_BITS-1:0];
  end

  // Count register and sticky underflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of statement order or block ordering.
    if (!reset_n) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (underflow_now) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccip_c0_req_arbiter.sv
// Round-robin arbiter from the per-instance c0 read request streams onto
// the shared CCI-P c0 Tx channel. Stamps the source index into the mdata
// tag bits, holds back while the channel is almost full, and tracks
// per-instance outstanding lines so no instance exceeds its tag share.
module ccip_c0_req_arbiter
  import pipearch_common::*;
#(
  parameter int NUM_INSTANCES   = 4,
  parameter int MAX_OUTSTANDING = CCIP_MAX_OUTSTANDING,
  parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_INSTANCES-1:0] req_valid,
  input  t_cci_c0_ReqMemHdr        req_hdr [NUM_INSTANCES],
  output logic [NUM_INSTANCES-1:0] req_ready,
  input  logic                     c0TxAlmFull,
  input  logic                     rsp_valid,
  input  t_cci_c0_RspMemHdr        rsp_hdr,
  output logic                     out_valid,
  output t_cci_c0_ReqMemHdr        out_hdr,
  output logic [CNT_BITS-1:0]      outstanding [NUM_INSTANCES],
  output logic                     underflow_err
);

  localparam int IDX_W = MDATA_TAG_HI - MDATA_TAG_LO + 1;

  logic [NUM_INSTANCES-1:0] eligible;
  logic [NUM_INSTANCES-1:0] room;
  logic [NUM_INSTANCES-1:0] uflow;
  logic [NUM_INSTANCES-1:0] dec_hit;
  logic [CCIP_LINES_W-1:0]  lines [NUM_INSTANCES];

  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_vld;
  logic [IDX_W:0]    cand;
  t_cci_c0_ReqMemHdr grant_hdr;

  logic [IDX_W-1:0]  rsp_tag;
  logic              rsp_rdline;
  logic              rsp_unused;

  assign rsp_tag    = rsp_hdr.mdata[MDATA_TAG_HI:MDATA_TAG_LO];
  assign rsp_rdline = rsp_valid && (rsp_hdr.resp_type == eRSP_RDLINE);

  // Response fields this block has no use for.
  assign rsp_unused = ^{rsp_hdr.vc_used, rsp_hdr.rsvd1, rsp_hdr.hit_miss,
                        rsp_hdr.rsvd0, rsp_hdr.cl_num,
                        rsp_hdr.mdata[MDATA_TAG_LO-1:0]};

  // Per-source line cost, eligibility and credit counter. Tags at or above
  // NUM_INSTANCES never match any source and are dropped here.
  for (genvar i = 0; i < NUM_INSTANCES; i++) begin : g_src
    assign lines[i]    = ccip_lines(req_hdr[i].cl_len);
    assign eligible[i] = req_valid[i] && !c0TxAlmFull && room[i];
    assign dec_hit[i]  = rsp_rdline && (rsp_tag == IDX_W'(i));

    ccip_credit_counter #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_BITS        (CNT_BITS)
    ) u_credit (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc_en    (req_ready[i]),
      .inc_lines (lines[i]),
      .dec_en    (dec_hit[i]),
      .chk_lines (lines[i]),
      .count     (outstanding[i]),
      .has_room  (room[i]),
      .underflow (uflow[i])
    );
  end

  // Round-robin pick: first eligible source scanning last+1, last+2, ...
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_INSTANCES; k++) begin
      cand = {1'b0, last} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_INSTANCES)) begin
        cand = cand - (IDX_W + 1)'(NUM_INSTANCES);
      end
      if (!grant_vld && eligible[cand[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  // One-hot ready toward the sources and the tag-stamped header.
  always_comb begin
    req_ready = '0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
    grant_hdr = req_hdr[grant_idx];
    grant_hdr.mdata[MDATA_TAG_HI:MDATA_TAG_LO] = grant_idx;
  end

  // Registered channel output and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_hdr   <= '0;
      last      <= IDX_W'(NUM_INSTANCES - 1);
    end else begin
      out_valid <= grant_vld;
      out_hdr   <= grant_vld ? grant_hdr : '0;
      if (grant_vld) begin
        last <= grant_idx;
      end
    end
  end

  assign underflow_err = |uflow;

endmodule

// File: tb/tb_ccip_c0_req_arbiter.sv
// Directed bench for ccip_c0_req_arbiter: single-source streaming,
// round-robin order, credit limit, same-cycle grant/return, almost-full
// backpressure, underflow and asynchronous reset.
module tb_ccip_c0_req_arbiter;
  import pipearch_common::*;

  localparam int N  = 4;
  localparam int CB = 7;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  t_cci_c0_ReqMemHdr req_hdr [N];
  logic [N-1:0]      req_ready;
  logic              c0TxAlmFull;
  logic              rsp_valid;
  t_cci_c0_RspMemHdr rsp_hdr;
  logic              out_valid;
  t_cci_c0_ReqMemHdr out_hdr;
  logic [CB-1:0]     outstanding [N];
  logic              underflow_err;

  int vectors     = 0;
  int miscompares = 0;

  ccip_c0_req_arbiter #(
    .NUM_INSTANCES   (N),
    .MAX_OUTSTANDING (64),
    .CNT_BITS        (CB)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_hdr       (req_hdr),
    .req_ready     (req_ready),
    .c0TxAlmFull   (c0TxAlmFull),
    .rsp_valid     (rsp_valid),
    .rsp_hdr       (rsp_hdr),
    .out_valid     (out_valid),
    .out_hdr       (out_hdr),
    .outstanding   (outstanding),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic t_cci_c0_ReqMemHdr mk_hdr(input logic [41:0] addr, input t_ccip_clLen len,
                                               input logic [15:0] md);
    t_cci_c0_ReqMemHdr h;
    h          = '0;
    h.cl_len   = len;
    h.req_type = eREQ_RDLINE_I;
    h.address  = addr;
    h.mdata    = md;
    return h;
  endfunction

  function automatic t_cci_c0_ReqMemHdr stamp(input t_cci_c0_ReqMemHdr h, input logic [1:0] tag);
    t_cci_c0_ReqMemHdr r;
    r             = h;
    r.mdata[15:14] = tag;
    return r;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rsp(input logic v, input logic [1:0] tag, input t_cci_c0_rsp ty);
    rsp_valid         = v;
    rsp_hdr           = '0;
    rsp_hdr.resp_type = ty;
    rsp_hdr.mdata     = {tag, 14'h0123};
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
    check({tag, "_out_hdr"}, 128'(out_hdr), 128'(0));
    for (int i = 0; i < N; i++) begin
      check({tag, "_outstanding"}, 128'(outstanding[i]), 128'(7'd0));
    end
    check({tag, "_underflow"}, 128'(underflow_err), 128'(1'b0));
  endtask

  logic [73:0] raw;
  int          rr_exp [4] = '{3, 0, 1, 3};

  initial begin
    reset_n     = 1'b0;
    req_valid   = '0;
    c0TxAlmFull = 1'b0;
    for (int i = 0; i < N; i++) req_hdr[i] = '0;
    set_rsp(1'b0, 2'd0, eRSP_RDLINE);
    #2;
    check_reset_state("reset");
    cyc();
    reset_n = 1'b1;
    cyc();

    // Instance 0 streams three single-line reads back to back.
    for (int k = 0; k < 3; k++) begin
      req_valid  = 4'b0001;
      req_hdr[0] = mk_hdr(42'h100 + 42'(k), eCL_LEN_1, 16'hC0DE);
      #1;
      check("t1_ready", 128'(req_ready), 128'(4'b0001));
      cyc();
      check("t1_valid", 128'(out_valid), 128'(1'b1));
      check("t1_hdr", 128'(out_hdr), 128'(stamp(req_hdr[0], 2'd0)));
      check("t1_count", 128'(outstanding[0]), 128'(k + 1));
    end
    req_valid = '0;
    cyc();
    check("t1_idle_valid", 128'(out_valid), 128'(1'b0));
    check("t1_idle_hdr", 128'(out_hdr), 128'(0));
    set_rsp(1'b1, 2'd0, eRSP_UMSG);
    cyc();
    check("t1_umsg_ignored", 128'(outstanding[0]), 128'(7'd3));
    set_rsp(1'b1, 2'd0, eRSP_RDLINE);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t1_return", 128'(outstanding[0]), 128'(2 - k));
    end
    set_rsp(1'b0, 2'd0, eRSP_RDLINE);
    check("t1_no_underflow", 128'(underflow_err), 128'(1'b0));

    // All four valid: grants rotate 0,1,2,3,0,...
    pulse_reset();
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) req_hdr[i] = mk_hdr(42'h200 + 42'(i), eCL_LEN_1, 16'hFFFF);
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t2_ready", 128'(req_ready), 128'(onehot(k % 4)));
      cyc();
      check("t2_hdr", 128'(out_hdr), 128'(stamp(req_hdr[k % 4], 2'(k % 4))));
    end
    req_valid = '0;
    cyc();
    check("t2_count", 128'(outstanding[1]), 128'(7'd2));

    // Instance 2 at 63 asking for 4 lines is skipped until credits return.
    pulse_reset();
    req_valid  = 4'b0100;
    req_hdr[2] = mk_hdr(42'h300, eCL_LEN_4, 16'h0000);
    repeat (15) cyc();
    req_hdr[2] = mk_hdr(42'h301, eCL_LEN_1, 16'h0000);
    repeat (3) cyc();
    check("t3_count63", 128'(outstanding[2]), 128'(7'd63));
    req_hdr[2] = mk_hdr(42'h302, eCL_LEN_4, 16'h0000);
    for (int i = 0; i < N; i++) if (i != 2) req_hdr[i] = mk_hdr(42'h310 + 42'(i), eCL_LEN_1, 16'h0000);
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3_skip_rr", 128'(req_ready), 128'(onehot(rr_exp[k])));
      cyc();
    end
    req_valid = 4'b0100;
    set_rsp(1'b1, 2'd2, eRSP_RDLINE);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_blocked", 128'(req_ready), 128'(4'b0000));
      cyc();
    end
    set_rsp(1'b0, 2'd0, eRSP_RDLINE);
    check("t3_count60", 128'(outstanding[2]), 128'(7'd60));
    #1;
    check("t3_ready_again", 128'(req_ready), 128'(4'b0100));
    cyc();
    check("t3_count64", 128'(outstanding[2]), 128'(7'd64));
    check("t3_hdr", 128'(out_hdr), 128'(stamp(req_hdr[2], 2'd2)));
    #1;
    check("t3_full", 128'(req_ready), 128'(4'b0000));
    req_valid = '0;
    cyc();

    // Same-cycle two-line grant and tag-1 return from count 5.
    pulse_reset();
    req_valid  = 4'b0010;
    req_hdr[1] = mk_hdr(42'h400, eCL_LEN_1, 16'h1234);
    repeat (5) cyc();
    check("t4_count5", 128'(outstanding[1]), 128'(7'd5));
    req_hdr[1] = mk_hdr(42'h401, eCL_LEN_2, 16'h5678);
    set_rsp(1'b1, 2'd1, eRSP_RDLINE);
    #1;
    check("t4_ready", 128'(req_ready), 128'(4'b0010));
    cyc();
    set_rsp(1'b0, 2'd0, eRSP_RDLINE);
    req_valid = '0;
    check("t4_count6", 128'(outstanding[1]), 128'(7'd6));
    check("t4_hdr", 128'(out_hdr), 128'(stamp(req_hdr[1], 2'd1)));
    check("t4_underflow", 128'(underflow_err), 128'(1'b0));

    // Almost-full blocks all grants; release resumes after last (=1).
    c0TxAlmFull = 1'b1;
    req_valid   = 4'hF;
    for (int i = 0; i < N; i++) req_hdr[i] = mk_hdr(42'h500 + 42'(i), eCL_LEN_1, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      #1;
      check("t5_ready_blocked", 128'(req_ready), 128'(4'b0000));
      cyc();
      check("t5_out_blocked", 128'(out_valid), 128'(1'b0));
    end
    c0TxAlmFull = 1'b0;
    #1;
    check("t5_resume_ready", 128'(req_ready), 128'(4'b0100));
    cyc();
    check("t5_resume_hdr", 128'(out_hdr), 128'(stamp(req_hdr[2], 2'd2)));
    req_valid = '0;
    cyc();

    // Illegal length costs 3; tag-3 return with no credit sets underflow.
    pulse_reset();
    raw        = mk_hdr(42'h600, eCL_LEN_1, 16'h0000);
    raw[69:68] = 2'b10;
    req_hdr[0] = raw;
    req_valid  = 4'b0001;
    cyc();
    req_valid = '0;
    check("t6_illegal_cost", 128'(outstanding[0]), 128'(7'd3));
    set_rsp(1'b1, 2'd3, eRSP_RDLINE);
    cyc();
    set_rsp(1'b0, 2'd0, eRSP_RDLINE);
    check("t6_underflow", 128'(underflow_err), 128'(1'b1));
    check("t6_count_floor", 128'(outstanding[3]), 128'(7'd0));
    cyc();
    check("t6_underflow_sticky", 128'(underflow_err), 128'(1'b1));
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) req_hdr[i] = mk_hdr(42'h700 + 42'(i), eCL_LEN_1, 16'h0000);
    cyc();
    cyc();
    check("t6_burst_valid", 128'(out_valid), 128'(1'b1));
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("t6_async");
    #1;
    reset_n   = 1'b1;
    req_valid = '0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
